// File: rtl/ofdm_preamble_inserter.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : ofdm_preamble_inserter
// Description : Transmit-side framer. Prepends a programmable run of zero
//               samples and a RAM-held preamble (short + long training
//               symbols) to each AXI-stream payload packet.
//               Optional feature macro: OFDM_PREAMBLE_INSERTER_BYPASS_EN
//               (adds settings address 4, bit0 = pass payload straight
//               through without gap or preamble).
// Revision    : 1.0 - initial release
//============================================================================
module ofdm_preamble_inserter #(
  parameter int         WIDTH                 = 32,
  parameter int         MAX_PREAMBLE_LEN_LOG2 = 9,
  parameter logic [7:0] SR_PREAMBLE_ADDR      = 8'd0,
  parameter logic [7:0] SR_PREAMBLE_DATA      = 8'd1,
  parameter logic [7:0] SR_PREAMBLE_LEN       = 8'd2,
  parameter logic [7:0] SR_GAP_LEN            = 8'd3
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             sof,
  output logic             eof
);

  localparam int              c_AW      = MAX_PREAMBLE_LEN_LOG2;
  localparam int              c_LW      = MAX_PREAMBLE_LEN_LOG2 + 1;
  localparam int              c_DEPTH   = 1 << MAX_PREAMBLE_LEN_LOG2;
  localparam logic [c_LW-1:0] c_LEN_MAX = c_LW'(c_DEPTH);
  localparam logic [c_LW-1:0] c_LEN_RST = c_LW'(320);
  localparam logic [c_LW-1:0] c_LEN_ONE = c_LW'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GAP      = 2'd1,
    S_PREAMBLE = 2'd2,
    S_PAYLOAD  = 2'd3
  } state_t;

  state_t           r_state;

  // Settings registers (take effect at the next packet start)
  logic [c_LW-1:0]  r_len;
  logic [15:0]      r_gap;
  logic [c_AW-1:0]  r_wptr;

  // Per-packet working copies latched when leaving IDLE
  logic [c_LW-1:0]  r_len_lat;
  logic [15:0]      r_gap_cnt;
  logic [c_LW-1:0]  r_pre_idx;

  // Preamble storage and its synchronous read register
  logic [WIDTH-1:0] r_ram [0:c_DEPTH-1];
  logic [WIDTH-1:0] r_ram_q;

  // r_sof_pend: the next emitted non-gap sample is the start of frame
  // r_out_first: the sample in the output register carries start of frame
  logic             r_sof_pend;
  logic             r_out_first;

  logic             w_load;
  logic             w_wr_addr;
  logic             w_wr_data;
  logic             w_wr_len;
  logic             w_wr_gap;
  logic [c_LW-1:0]  w_len_sat;
  logic [c_LW-1:0]  w_pre_next;
  logic [c_AW-1:0]  w_raddr;
  logic             w_fwd;
  logic             w_bypass;

  // Output register may take a new sample when empty or being drained
  assign w_load   = !o_tvalid || o_tready;

  // Payload is only pulled once the preamble has been fully emitted
  assign i_tready = (r_state == S_PAYLOAD) && w_load;

  assign sof      = o_tvalid && o_tready && r_out_first;
  assign eof      = o_tvalid && o_tready && o_tlast;

  assign w_wr_addr = set_stb && (set_addr == SR_PREAMBLE_ADDR);
  assign w_wr_data = set_stb && (set_addr == SR_PREAMBLE_DATA) && (r_state == S_IDLE);
  assign w_wr_len  = set_stb && (set_addr == SR_PREAMBLE_LEN);
  assign w_wr_gap  = set_stb && (set_addr == SR_GAP_LEN);
  assign w_len_sat = (set_data > 32'(c_DEPTH)) ? c_LEN_MAX : set_data[c_LW-1:0];

  // Read address runs one sample ahead of the output so the synchronous
  // RAM never introduces a bubble; outside PREAMBLE sample 0 is prefetched.
  always_comb begin
    w_pre_next = r_pre_idx + c_LEN_ONE;
    w_raddr    = '0;
    if (r_state == S_PREAMBLE) begin
      w_raddr = w_load ? w_pre_next[c_AW-1:0] : r_pre_idx[c_AW-1:0];
    end
  end

  // A write landing on the address being prefetched must be seen immediately
  assign w_fwd = w_wr_data && (r_wptr == w_raddr);

`ifdef OFDM_PREAMBLE_INSERTER_BYPASS_EN
  localparam logic [7:0] c_SR_BYPASS = 8'd4;

  logic r_bypass;

  // Bypass control bit, sampled when a packet starts
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_bypass <= 1'b0;
    end else if (set_stb && (set_addr == c_SR_BYPASS)) begin
      r_bypass <= set_data[0];
    end
  end

  assign w_bypass = r_bypass;
`else
  assign w_bypass = 1'b0;
`endif

  // Settings bus: length, gap and RAM write pointer
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_len  <= c_LEN_RST;
      r_gap  <= '0;
      r_wptr <= '0;
    end else begin
      if (w_wr_addr) begin
        r_wptr <= set_data[c_AW-1:0];
      end else if (w_wr_data) begin
        r_wptr <= r_wptr + c_AW'(1);
      end
      if (w_wr_len) begin
        r_len <= w_len_sat;
      end
      if (w_wr_gap) begin
        r_gap <= set_data[15:0];
      end
    end
  end

  // Preamble RAM: write port from settings, registered read port
  always_ff @(posedge clk) begin
    if (w_wr_data) begin
      r_ram[r_wptr] <= set_data[WIDTH-1:0];
    end
    r_ram_q <= w_fwd ? set_data[WIDTH-1:0] : r_ram[w_raddr];
  end

  // Framing state machine with registered output stage
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      o_tvalid    <= 1'b0;
      o_tlast     <= 1'b0;
      o_tdata     <= '0;
      r_out_first <= 1'b0;
      r_sof_pend  <= 1'b0;
      r_len_lat   <= c_LEN_RST;
      r_gap_cnt   <= '0;
      r_pre_idx   <= '0;
    end else if (clear) begin
      r_state     <= S_IDLE;
      o_tvalid    <= 1'b0;
      o_tlast     <= 1'b0;
      r_out_first <= 1'b0;
      r_sof_pend  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            o_tvalid    <= 1'b0;
            o_tlast     <= 1'b0;
            r_out_first <= 1'b0;
          end
          if (i_tvalid) begin
            r_len_lat  <= r_len;
            r_gap_cnt  <= r_gap;
            r_pre_idx  <= '0;
            r_sof_pend <= 1'b1;
            if (w_bypass || ((r_gap == '0) && (r_len == '0))) begin
              r_state <= S_PAYLOAD;
            end else if (r_gap != '0) begin
              r_state <= S_GAP;
            end else begin
              r_state <= S_PREAMBLE;
            end
          end
        end

        S_GAP: begin
          if (w_load) begin
            o_tvalid    <= 1'b1;
            o_tdata     <= '0;
            o_tlast     <= 1'b0;
            r_out_first <= 1'b0;
            r_gap_cnt   <= r_gap_cnt - 16'd1;
            if (r_gap_cnt == 16'd1) begin
              r_state <= (r_len_lat == '0) ? S_PAYLOAD : S_PREAMBLE;
            end
          end
        end

        S_PREAMBLE: begin
          if (w_load) begin
            o_tvalid    <= 1'b1;
            o_tdata     <= r_ram_q;
            o_tlast     <= 1'b0;
            r_out_first <= r_sof_pend;
            r_sof_pend  <= 1'b0;
            r_pre_idx   <= w_pre_next;
            if (r_pre_idx == (r_len_lat - c_LEN_ONE)) begin
              r_state <= S_PAYLOAD;
            end
          end
        end

        S_PAYLOAD: begin
          if (w_load) begin
            if (i_tvalid) begin
              o_tvalid    <= 1'b1;
              o_tdata     <= i_tdata;
              o_tlast     <= i_tlast;
              r_out_first <= r_sof_pend;
              r_sof_pend  <= 1'b0;
              if (i_tlast) begin
                r_state <= S_IDLE;
              end
            end else begin
              o_tvalid    <= 1'b0;
              o_tlast     <= 1'b0;
              r_out_first <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
